instr_ctrl_fsm: RTL and testbench
=================================

// Module: instr_ctrl_fsm
// PURPOSE
//  Instruction-cycle controller for the simple RISC CPU. Consumes fetch from the
//  clock generator and sequences 8 clk-wide micro-steps (S0..S7) per instruction.
//  Decodes the 3-bit opcode and the accumulator zero flag into one-hot-ish
//  control strobes for PC, IR, ACC, memory read/write and the data-bus driver.
// PARAMETERS
//  OP_W    3   opcode width (fixed ISA encoding below; not meant to be changed)
//  NSTEP   8   micro-steps per instruction; must equal the fetch period in clk cycles
// PORTS
//  clk          in   1     system clock
//  reset        in   1     synchronous, active-high
//  fetch        in   1     clock-generator fetch phase (high 4 of every 8 clk)
//  opcode       in   3     IR[7:5], valid from S2 onward
//  zero         in   1     accumulator == 0
//  inc_pc       out  1     increment program counter
//  load_acc     out  1     load accumulator from ALU
//  load_pc      out  1     load PC from IR address field
//  rd           out  1     memory read
//  wr           out  1     memory write
//  load_ir      out  1     load instruction register
//  datactl_ena  out  1     drive ALU result onto data bus
//  halt         out  1     CPU halted
// BEHAVIOUR
//  - Reset: run=0, state=S0, fetch_d=0, all outputs 0. Reset mid-instruction
//    aborts it immediately; no strobe survives the reset edge.
//  - fetch_d <= fetch each clk; rise = fetch & ~fetch_d.
//  - run: set on first rise after reset; cleared only by reset.
//  - state: on rise -> S0 (resync, overrides any state incl. mid-sequence);
//    else if run & ~halted: S0->S1->..->S7->S0. Not run: hold S0.
//  - Outputs registered: at each clk with run & ~halted, outputs <= TABLE[state];
//    strobes for step Sn are visible the cycle after state==Sn (1-clk latency).
//    run==0 -> all outputs 0.
//  - Opcodes: HLT=000 SKZ=001 ADD=010 AND=011 XOR=100 LDA=101 STO=110 JMP=111;
//    ALUOP = ADD|AND|XOR|LDA.
//  - TABLE (unlisted strobes 0):
//    S0: rd, load_ir          S1: rd, load_ir, inc_pc        S2: none
//    S3: HLT -> halt (sets halted); others -> inc_pc
//    S4: ALUOP -> rd; JMP -> load_pc; STO -> datactl_ena
//    S5: ALUOP -> rd, load_acc; SKZ&zero -> inc_pc; JMP -> inc_pc, load_pc;
//        STO -> datactl_ena
//    S6: STO -> wr, datactl_ena; ALUOP -> rd
//    S7: SKZ&zero -> inc_pc
//  - zero sampled in S5 and S7 independently (may differ; each step uses own sample).
//  - halted: set when state==S3 & opcode==HLT. While halted: state frozen, halt=1,
//    all other strobes 0, fetch rises ignored.
//  - Never rd&wr together; wr only when datactl_ena also 1.
// CONFIGURATION
//  INSTR_CTRL_RESUME_EN defined: adds input `resume` (1 bit). resume=1 while halted
//    clears halted and halt at next clk; state returns to S0 and waits for next
//    fetch rise before stepping. resume ignored when not halted.
//  Undefined: no resume port; halted exits only via reset.
// TESTING
//  1 reset 3 clk, fetch held 0 -> all outputs 0, no stepping for 20 clk.
//  2 fetch from clk_gen, opcode=ADD(010) -> per 8 clk: rd,load_ir / rd,load_ir,inc_pc /
//    0 / inc_pc / rd / rd,load_acc / rd / 0; repeats every 8 clk.
//  3 opcode=SKZ, zero=1 -> inc_pc in S3,S5,S7 (3 pulses); zero=0 -> inc_pc in S3 only.
//  4 opcode=STO -> datactl_ena S4-S6, wr S6 only, rd never with wr.
//  5 opcode=HLT -> halt=1 after S3, outputs frozen 30 clk despite fetch; reset -> halt=0.
//  6 reset asserted at S5 of JMP -> load_pc/inc_pc low next clk; resync on next fetch rise;
//    with INSTR_CTRL_RESUME_EN, resume pulse after HLT -> halt=0, S0 on next fetch rise.

Source files
------------

// File: rtl/instr_ctrl_fsm.sv
// Instruction-cycle controller: resyncs to fetch rises and walks S0..S7, producing registered control strobes.
// Optional build macro INSTR_CTRL_RESUME_EN adds a resume input that releases the halted state.
module instr_ctrl_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic       fetch,
  input  logic [2:0] opcode,
  input  logic       zero,
`ifdef INSTR_CTRL_RESUME_EN
  input  logic       resume,
`endif
  output logic       inc_pc,
  output logic       load_acc,
  output logic       load_pc,
  output logic       rd,
  output logic       wr,
  output logic       load_ir,
  output logic       datactl_ena,
  output logic       halt
);

  localparam int unsigned OP_W  = 3;
  localparam int unsigned NSTEP = 8;
  localparam int unsigned ST_W  = $clog2(NSTEP);

  localparam logic [OP_W-1:0] OP_HLT = 3'b000;
  localparam logic [OP_W-1:0] OP_SKZ = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_AND = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_LDA = 3'b101;
  localparam logic [OP_W-1:0] OP_STO = 3'b110;
  localparam logic [OP_W-1:0] OP_JMP = 3'b111;

  typedef enum logic [ST_W-1:0] {S0, S1, S2, S3, S4, S5, S6, S7} state_e;

  state_e state, state_nxt;
  logic   fetch_d, run, run_nxt, halted, halted_nxt;
  // rearm: after a resume, park in S0 until the next fetch rise
  logic   rearm, rearm_nxt;
  logic   inc_pc_nxt, load_acc_nxt, load_pc_nxt, rd_nxt, wr_nxt;
  logic   load_ir_nxt, datactl_ena_nxt, halt_nxt;
  logic   rise, active, is_alu, is_skz, is_sto, is_jmp;

  assign rise   = fetch & ~fetch_d;
  assign active = run & ~rearm;
  assign is_alu = (opcode == OP_ADD) | (opcode == OP_AND) |
                  (opcode == OP_XOR) | (opcode == OP_LDA);
  assign is_skz = (opcode == OP_SKZ);
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);

  // State, sequencing flags and registered strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S0;
      fetch_d     <= 1'b0;
      run         <= 1'b0;
      halted      <= 1'b0;
      rearm       <= 1'b0;
      inc_pc      <= 1'b0;
      load_acc    <= 1'b0;
      load_pc     <= 1'b0;
      rd          <= 1'b0;
      wr          <= 1'b0;
      load_ir     <= 1'b0;
      datactl_ena <= 1'b0;
      halt        <= 1'b0;
    end else begin
      state       <= state_nxt;
      fetch_d     <= fetch;
      run         <= run_nxt;
      halted      <= halted_nxt;
      rearm       <= rearm_nxt;
      inc_pc      <= inc_pc_nxt;
      load_acc    <= load_acc_nxt;
      load_pc     <= load_pc_nxt;
      rd          <= rd_nxt;
      wr          <= wr_nxt;
      load_ir     <= load_ir_nxt;
      datactl_ena <= datactl_ena_nxt;
      halt        <= halt_nxt;
    end
  end

  // Next state and strobe decode for the step currently in progress
  always_comb begin
    state_nxt       = state;
    run_nxt         = run;
    halted_nxt      = halted;
    rearm_nxt       = rearm;
    inc_pc_nxt      = 1'b0;
    load_acc_nxt    = 1'b0;
    load_pc_nxt     = 1'b0;
    rd_nxt          = 1'b0;
    wr_nxt          = 1'b0;
    load_ir_nxt     = 1'b0;
    datactl_ena_nxt = 1'b0;
    halt_nxt        = 1'b0;

    if (halted) begin
      halt_nxt = 1'b1;
`ifdef INSTR_CTRL_RESUME_EN
      if (resume) begin
        halt_nxt   = 1'b0;
        halted_nxt = 1'b0;
        state_nxt  = S0;
        rearm_nxt  = 1'b1;
      end
`endif
    end else begin
      if (active) begin
        unique case (state)
          S0: begin
            rd_nxt      = 1'b1;
            load_ir_nxt = 1'b1;
          end
          S1: begin
            rd_nxt      = 1'b1;
            load_ir_nxt = 1'b1;
            inc_pc_nxt  = 1'b1;
          end
          S2: ;
          S3: begin
            if (opcode == OP_HLT) begin
              halt_nxt   = 1'b1;
              halted_nxt = 1'b1;
            end else begin
              inc_pc_nxt = 1'b1;
            end
          end
          S4: begin
            rd_nxt          = is_alu;
            load_pc_nxt     = is_jmp;
            datactl_ena_nxt = is_sto;
          end
          S5: begin
            rd_nxt          = is_alu;
            load_acc_nxt    = is_alu;
            inc_pc_nxt      = (is_skz & zero) | is_jmp;
            load_pc_nxt     = is_jmp;
            datactl_ena_nxt = is_sto;
          end
          S6: begin
            wr_nxt          = is_sto;
            datactl_ena_nxt = is_sto;
            rd_nxt          = is_alu;
          end
          S7: inc_pc_nxt = is_skz & zero;
          default: ;
        endcase
        state_nxt = state_e'(state + ST_W'(1));
      end
      if (rise) begin
        run_nxt   = 1'b1;
        rearm_nxt = 1'b0;
        state_nxt = S0;
      end
    end
  end

endmodule

// File: tb/tb_instr_ctrl_fsm.sv
// Directed bench for instr_ctrl_fsm; define INSTR_CTRL_RESUME_EN to also exercise resume.
module tb_instr_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset, fetch, zero;
  logic [2:0] opcode;
  logic       resume;
  logic       inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt;
  logic [7:0] obs;

  int n_tests = 0;
  int n_fail  = 0;
  logic       fetch_en;
  logic [2:0] ph;

  always #5 clk = ~clk;

  instr_ctrl_fsm dut (
    .clk         (clk),
    .reset       (reset),
    .fetch       (fetch),
    .opcode      (opcode),
    .zero        (zero),
`ifdef INSTR_CTRL_RESUME_EN
    .resume      (resume),
`endif
    .inc_pc      (inc_pc),
    .load_acc    (load_acc),
    .load_pc     (load_pc),
    .rd          (rd),
    .wr          (wr),
    .load_ir     (load_ir),
    .datactl_ena (datactl_ena),
    .halt        (halt)
  );

  // {inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt}
  assign obs = {inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt};

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, want);
    end
  endtask

  // One clk: fetch (4 high / 4 low) changes on the falling edge, sample 1ns after rising edge
  task automatic cyc();
    @(negedge clk);
    if (fetch_en) begin
      fetch = (ph < 3'd4);
      ph    = ph + 3'd1;
    end else begin
      fetch = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // exp holds the strobe byte seen after steps S0..S7, S0 in the top byte
  task automatic run_instr(input string tag, input logic [2:0] op, input logic z5,
                           input logic z7, input logic [63:0] exp);
    logic [63:0] e;
    e = exp;
    opcode = op;
    for (int k = 0; k < 8; k++) begin
      zero = (k >= 6) ? z7 : z5;
      cyc();
      check($sformatf("%s_s%0d", tag, k), obs, e[63-8*k -: 8]);
    end
  endtask

  localparam logic [63:0] EXP_ALU  = 64'h14_94_00_80_10_50_10_00;
  localparam logic [63:0] EXP_SKZ1 = 64'h14_94_00_80_00_80_00_80;
  localparam logic [63:0] EXP_SKZ0 = 64'h14_94_00_80_00_00_00_00;
  localparam logic [63:0] EXP_SKZM = 64'h14_94_00_80_00_80_00_00;
  localparam logic [63:0] EXP_STO  = 64'h14_94_00_80_02_02_0A_00;
  localparam logic [63:0] EXP_JMP  = 64'h14_94_00_80_20_A0_00_00;
  localparam logic [63:0] EXP_HLT  = 64'h14_94_00_01_01_01_01_01;

  initial begin
    logic [63:0] ej;
    reset = 1'b1; fetch = 1'b0; zero = 1'b0; opcode = 3'b010; resume = 1'b0;
    fetch_en = 1'b0; ph = 3'd0;

    repeat (3) cyc();
    check("reset", obs, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check($sformatf("idle%0d", i), obs, 8'h00);
    end

    fetch_en = 1'b1; ph = 3'd0;
    cyc();
    check("first_rise", obs, 8'h00);
    run_instr("add_a", 3'b010, 1'b0, 1'b0, EXP_ALU);
    run_instr("add_b", 3'b010, 1'b1, 1'b1, EXP_ALU);
    run_instr("xor",   3'b100, 1'b0, 1'b0, EXP_ALU);
    run_instr("skz11", 3'b001, 1'b1, 1'b1, EXP_SKZ1);
    run_instr("skz00", 3'b001, 1'b0, 1'b0, EXP_SKZ0);
    run_instr("skz10", 3'b001, 1'b1, 1'b0, EXP_SKZM);
    run_instr("sto",   3'b110, 1'b0, 1'b0, EXP_STO);
    run_instr("jmp",   3'b111, 1'b1, 1'b1, EXP_JMP);
    run_instr("lda",   3'b101, 1'b0, 1'b0, EXP_ALU);
    run_instr("hlt",   3'b000, 1'b0, 1'b0, EXP_HLT);
    for (int i = 0; i < 30; i++) begin
      cyc();
      check($sformatf("halted%0d", i), obs, 8'h01);
    end

`ifdef INSTR_CTRL_RESUME_EN
    fetch_en = 1'b0;
    cyc();
    check("halt_hold", obs, 8'h01);
    resume = 1'b1;
    cyc();
    check("resume", obs, 8'h00);
    resume = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check($sformatf("rearm%0d", i), obs, 8'h00);
    end
    fetch_en = 1'b1; ph = 3'd0;
    cyc();
    check("resume_rise", obs, 8'h00);
    run_instr("add_res", 3'b010, 1'b0, 1'b0, EXP_ALU);
`endif

    fetch_en = 1'b0;
    reset = 1'b1;
    cyc();
    check("halt_reset", obs, 8'h00);
    reset = 1'b0;
    cyc();
    check("post_reset", obs, 8'h00);

    // Reset while JMP is in S5: strobes must not appear, then resync on next rise
    fetch_en = 1'b1; ph = 3'd0;
    cyc();
    check("jmp2_rise", obs, 8'h00);
    opcode = 3'b111;
    ej = EXP_JMP;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check($sformatf("jmp2_s%0d", k), obs, ej[63-8*k -: 8]);
    end
    reset = 1'b1;
    cyc();
    check("jmp2_rst", obs, 8'h00);
    reset = 1'b0;
    cyc();
    check("resync_wait", obs, 8'h00);
    cyc();
    check("resync_rise", obs, 8'h00);
    run_instr("add_sync", 3'b010, 1'b0, 1'b0, EXP_ALU);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
